// File: rtl/plus_dma_sched.sv
// plus_dma_sched
// Three-channel PSG DMA scheduler. Each rising edge of hsync_i starts one
// scheduling pass. The pass visits channels 0, 1 and 2 in that order and runs
// at most one instruction per channel. A channel fetches one 16-bit word from
// its own address pointer and decodes it:
//   0xxx LOAD     write word[7:0] to PSG register word[11:8]
//   1nnn PAUSE    skip n*(prescaler+1) passes (n=0 is a no-op)
//   2nnn REPEAT   arm the loop counter with n; the loop target is the next word
//   4xxx CONTROL  bit0 LOOP, bit4 INT, bit5 STOP
//   others        no-op
//
// Ports
//   clk, reset_n          clock; synchronous active-low reset
//   hsync_i               horizontal sync level; a rising edge starts a pass
//   cfg_we/sel/field/data per-channel configuration write port
//   mem_req/addr/ack/data instruction fetch handshake (req held until ack)
//   psg_req/reg/data/ack  PSG register write handshake (req held until ack)
//   ch_active             per-channel enable status
//   dma_irq, irq_clr      sticky per-channel INT flags and their clears
//   overrun               sticky: an hsync edge arrived while a pass was running
module plus_dma_sched (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hsync_i,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_sel,
    input  logic [1:0]  cfg_field,
    input  logic [7:0]  cfg_data,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic        psg_req,
    output logic [3:0]  psg_reg,
    output logic [7:0]  psg_data,
    input  logic        psg_ack,
    output logic [2:0]  ch_active,
    output logic [2:0]  dma_irq,
    input  logic [2:0]  irq_clr,
    output logic        overrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FETCH,
        ST_EXEC,
        ST_PSG_WR,
        ST_NEXT
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ch_q, ch_d;
    logic        hsync_q;
    logic        hsync_rise;
    logic [15:0] word_q, word_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [3:0]  psg_reg_q, psg_reg_d;
    logic [7:0]  psg_data_q, psg_data_d;
    logic [2:0]  active_q, active_d;
    logic [2:0]  irq_q, irq_d;
    logic        overrun_q, overrun_d;

    // Per-channel registers
    logic [15:0] addr_q      [3];
    logic [15:0] addr_d      [3];
    logic [7:0]  presc_q     [3];
    logic [7:0]  presc_d     [3];
    logic [7:0]  presc_cnt_q [3];
    logic [7:0]  presc_cnt_d [3];
    logic [11:0] pause_q     [3];
    logic [11:0] pause_d     [3];
    logic [11:0] loop_cnt_q  [3];
    logic [11:0] loop_cnt_d  [3];
    logic [15:0] loop_addr_q [3];
    logic [15:0] loop_addr_d [3];

    logic [2:0]  cfg_hit;   // config write addressed to channel
    logic [2:0]  cfg_clr;   // config write clearing channel enable this cycle
    logic [3:0]  op;
    logic [11:0] arg;

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        assign cfg_hit[gi] = cfg_we && (cfg_sel == 2'(gi));
        assign cfg_clr[gi] = cfg_hit[gi] && (cfg_field == 2'd3) && cfg_data[1];
    end

    assign op         = word_q[15:12];
    assign arg        = word_q[11:0];
    assign hsync_rise = hsync_i && !hsync_q;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        word_d     = word_q;
        mem_addr_d = mem_addr_q;
        psg_reg_d  = psg_reg_q;
        psg_data_d = psg_data_q;
        active_d   = active_q;
        // Clear first so that an INT in the same cycle wins.
        irq_d      = irq_q & ~irq_clr;
        overrun_d  = overrun_q;
        for (int i = 0; i < 3; i++) begin
            addr_d[i]      = addr_q[i];
            presc_d[i]     = presc_q[i];
            presc_cnt_d[i] = presc_cnt_q[i];
            pause_d[i]     = pause_q[i];
            loop_cnt_d[i]  = loop_cnt_q[i];
            loop_addr_d[i] = loop_addr_q[i];
        end

        // An edge during a pass is only flagged; the pass runs on unchanged.
        if (hsync_rise && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hsync_rise) begin
                    state_d = ST_SCAN;
                    ch_d    = 2'd0;
                end
            end

            ST_SCAN: begin
                if (!active_q[ch_q]) begin
                    state_d = ST_NEXT;
                end else if (pause_q[ch_q] != 12'd0) begin
                    if (presc_cnt_q[ch_q] == 8'd0) begin
                        presc_cnt_d[ch_q] = presc_q[ch_q];
                        pause_d[ch_q]     = pause_q[ch_q] - 12'd1;
                    end else begin
                        presc_cnt_d[ch_q] = presc_cnt_q[ch_q] - 8'd1;
                    end
                    state_d = ST_NEXT;
                end else begin
                    // Address is captured here so a config write during the
                    // handshake cannot disturb the request on the bus.
                    mem_addr_d = {addr_q[ch_q][15:1], 1'b0};
                    state_d    = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (mem_ack) begin
                    word_d       = mem_data;
                    addr_d[ch_q] = mem_addr_q + 16'd2;
                    // A channel disabled while its fetch was outstanding
                    // drops the fetched word.
                    state_d = (active_q[ch_q] && !cfg_clr[ch_q]) ? ST_EXEC : ST_NEXT;
                end
            end

            ST_EXEC: begin
                state_d = ST_NEXT;
                if (active_q[ch_q] && !cfg_clr[ch_q]) begin
                    case (op)
                        4'h0: begin
                            psg_reg_d  = word_q[11:8];
                            psg_data_d = word_q[7:0];
                            state_d    = ST_PSG_WR;
                        end
                        4'h1: begin
                            if (arg != 12'd0) begin
                                pause_d[ch_q]     = arg;
                                presc_cnt_d[ch_q] = presc_q[ch_q];
                            end
                        end
                        4'h2: begin
                            loop_cnt_d[ch_q]  = arg;
                            loop_addr_d[ch_q] = addr_q[ch_q];
                        end
                        4'h4: begin
                            if (word_q[0] && (loop_cnt_q[ch_q] != 12'd0)) begin
                                loop_cnt_d[ch_q] = loop_cnt_q[ch_q] - 12'd1;
                                addr_d[ch_q]     = loop_addr_q[ch_q];
                            end
                            if (word_q[4]) begin
                                irq_d[ch_q] = 1'b1;
                            end
                            if (word_q[5]) begin
                                active_d[ch_q] = 1'b0;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end

            ST_PSG_WR: begin
                if (psg_ack) begin
                    state_d = ST_NEXT;
                end
            end

            ST_NEXT: begin
                if (ch_q == 2'd2) begin
                    state_d = ST_IDLE;
                end else begin
                    ch_d    = ch_q + 2'd1;
                    state_d = ST_SCAN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Configuration writes are applied last so they override the
        // scheduler's own update of the same register in the same cycle.
        for (int i = 0; i < 3; i++) begin
            if (cfg_hit[i]) begin
                case (cfg_field)
                    2'd0: addr_d[i][7:0]  = cfg_data;
                    2'd1: addr_d[i][15:8] = cfg_data;
                    2'd2: presc_d[i]      = cfg_data;
                    2'd3: begin
                        if (cfg_data[1]) begin
                            active_d[i] = 1'b0;
                        end else if (cfg_data[0]) begin
                            active_d[i]   = 1'b1;
                            pause_d[i]    = 12'd0;
                            loop_cnt_d[i] = 12'd0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ch_q       <= 2'd0;
            hsync_q    <= 1'b0;
            word_q     <= 16'd0;
            mem_addr_q <= 16'd0;
            psg_reg_q  <= 4'd0;
            psg_data_q <= 8'd0;
            active_q   <= 3'b000;
            irq_q      <= 3'b000;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            hsync_q    <= hsync_i;
            word_q     <= word_d;
            mem_addr_q <= mem_addr_d;
            psg_reg_q  <= psg_reg_d;
            psg_data_q <= psg_data_d;
            active_q   <= active_d;
            irq_q      <= irq_d;
            overrun_q  <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                addr_q[i]      <= 16'd0;
                presc_q[i]     <= 8'd0;
                presc_cnt_q[i] <= 8'd0;
                pause_q[i]     <= 12'd0;
                loop_cnt_q[i]  <= 12'd0;
                loop_addr_q[i] <= 16'd0;
            end else begin
                addr_q[i]      <= addr_d[i];
                presc_q[i]     <= presc_d[i];
                presc_cnt_q[i] <= presc_cnt_d[i];
                pause_q[i]     <= pause_d[i];
                loop_cnt_q[i]  <= loop_cnt_d[i];
                loop_addr_q[i] <= loop_addr_d[i];
            end
        end
    end

    // Requests are decoded from the state register, so they cannot drop
    // before their ack and can never be high together.
    assign mem_req   = (state_q == ST_FETCH);
    assign psg_req   = (state_q == ST_PSG_WR);
    assign mem_addr  = mem_addr_q;
    assign psg_reg   = psg_reg_q;
    assign psg_data  = psg_data_q;
    assign ch_active = active_q;
    assign dma_irq   = irq_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_plus_dma_sched.sv
// tb_plus_dma_sched
// Drives plus_dma_sched with directed scenarios followed by randomized channel
// programs. Memory and PSG are modelled by responders with random ack delays.
// A pass-level reference model predicts every fetch address, every PSG write,
// ch_active and dma_irq.
module tb_plus_dma_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hsync_i;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [1:0]  cfg_field;
    logic [7:0]  cfg_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        psg_req;
    logic [3:0]  psg_reg;
    logic [7:0]  psg_data;
    logic        psg_ack;
    logic [2:0]  ch_active;
    logic [2:0]  dma_irq;
    logic [2:0]  irq_clr;
    logic        overrun;

    always #5 clk = ~clk;

    plus_dma_sched dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .hsync_i   (hsync_i),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_field (cfg_field),
        .cfg_data  (cfg_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .psg_req   (psg_req),
        .psg_reg   (psg_reg),
        .psg_data  (psg_data),
        .psg_ack   (psg_ack),
        .ch_active (ch_active),
        .dma_irq   (dma_irq),
        .irq_clr   (irq_clr),
        .overrun   (overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- memory image and responders ----------------
    logic [15:0] mem_m [logic [15:0]];

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return 16'hF000;  // unprogrammed words decode as no-op
    endfunction

    logic [15:0] fetch_log [$];
    logic [11:0] psg_log   [$];

    int         mem_dly_max = 0;
    int         mem_fix_dly = -1;
    bit         clr_at_int  = 1'b0;
    logic [2:0] man_clr_val = 3'b000;
    int         man_clr_seq = 0;
    bit         psg_hold    = 1'b0;
    int         late_ack_seq = 0;

    initial begin : mem_resp
        int wait_left;
        bit exec_clr;
        int seen;
        wait_left = -1;
        exec_clr  = 1'b0;
        seen      = 0;
        mem_ack   = 1'b0;
        mem_data  = 16'd0;
        irq_clr   = 3'b000;
        forever begin
            @(negedge clk);
            mem_ack  = 1'b0;
            irq_clr  = exec_clr ? 3'b001 : 3'b000;
            exec_clr = 1'b0;
            if (man_clr_seq != seen) begin
                irq_clr = irq_clr | man_clr_val;
                seen    = man_clr_seq;
            end
            if (mem_req) begin
                if (wait_left < 0)
                    wait_left = (mem_fix_dly >= 0) ? mem_fix_dly : int'($urandom_range(mem_dly_max, 0));
                if (wait_left == 0) begin
                    mem_ack   = 1'b1;
                    mem_data  = mem_rd(mem_addr);
                    fetch_log.push_back(mem_addr);
                    wait_left = -1;
                    exec_clr  = clr_at_int;  // clear lands in the decode cycle
                end else begin
                    wait_left--;
                end
            end else begin
                wait_left = -1;
            end
        end
    end

    initial begin : psg_resp
        int wait_left;
        int seen;
        wait_left = -1;
        seen      = 0;
        psg_ack   = 1'b0;
        forever begin
            @(negedge clk);
            psg_ack = 1'b0;
            if (late_ack_seq != seen) begin
                psg_ack = 1'b1;
                seen    = late_ack_seq;
            end else if (psg_req && !psg_hold) begin
                if (wait_left < 0) wait_left = int'($urandom_range(mem_dly_max, 0));
                if (wait_left == 0) begin
                    psg_ack = 1'b1;
                    psg_log.push_back({psg_reg, psg_data});
                    wait_left = -1;
                end else begin
                    wait_left--;
                end
            end else begin
                wait_left = -1;
            end
        end
    end

    // ---------------- pass-level reference model ----------------
    logic [15:0] m_addr      [3];
    logic [15:0] m_loop_addr [3];
    int          m_skip      [3];   // passes still to be skipped
    int          m_presc     [3];
    int          m_loop      [3];
    logic [2:0]  m_active;
    logic [2:0]  m_irq;
    logic [15:0] exp_fetch [$];
    logic [11:0] exp_psg   [$];
    int          fetch_rd = 0;
    int          psg_rd   = 0;

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_addr[c] = 16'd0; m_loop_addr[c] = 16'd0;
            m_skip[c] = 0; m_presc[c] = 0; m_loop[c] = 0;
        end
        m_active = 3'b000;
        m_irq    = 3'b000;
        exp_fetch.delete();
        exp_psg.delete();
        fetch_rd = fetch_log.size();
        psg_rd   = psg_log.size();
    endtask

    task automatic model_pass();
        logic [15:0] a;
        logic [15:0] w;
        for (int c = 0; c < 3; c++) begin
            if (m_active[c]) begin
                if (m_skip[c] > 0) begin
                    m_skip[c]--;
                end else begin
                    a = {m_addr[c][15:1], 1'b0};
                    w = mem_rd(a);
                    exp_fetch.push_back(a);
                    m_addr[c] = a + 16'd2;
                    case (w[15:12])
                        4'h0: exp_psg.push_back(w[11:0]);
                        4'h1: m_skip[c] = int'(w[11:0]) * (m_presc[c] + 1);
                        4'h2: begin m_loop[c] = int'(w[11:0]); m_loop_addr[c] = m_addr[c]; end
                        4'h4: begin
                            if (w[0] && m_loop[c] != 0) begin
                                m_loop[c]--;
                                m_addr[c] = m_loop_addr[c];
                            end
                            if (w[4]) m_irq[c] = 1'b1;
                            if (w[5]) m_active[c] = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cfg_write(input int sel, input int field, input logic [7:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_field = 2'(field); cfg_data = data;
        @(negedge clk);
        cfg_we = 1'b0;
        case (field)
            0: m_addr[sel][7:0]  = data;
            1: m_addr[sel][15:8] = data;
            2: m_presc[sel]      = int'(data);
            default: begin
                if (data[1]) m_active[sel] = 1'b0;
                else if (data[0]) begin m_active[sel] = 1'b1; m_skip[sel] = 0; m_loop[sel] = 0; end
            end
        endcase
    endtask

    task automatic set_chan(input int sel, input logic [15:0] a, input logic [7:0] p);
        cfg_write(sel, 0, a[7:0]);
        cfg_write(sel, 1, a[15:8]);
        cfg_write(sel, 2, p);
        cfg_write(sel, 3, 8'h01);
    endtask

    task automatic irq_clear(input logic [2:0] bits);
        man_clr_val = bits;
        man_clr_seq++;
        repeat (3) @(negedge clk);
        m_irq = m_irq & ~bits;
    endtask

    task automatic hsync_pulse();
        @(negedge clk); hsync_i = 1'b1;
        @(negedge clk); hsync_i = 1'b0;
    endtask

    task automatic check_logs(input string tag, output int nf, output int np);
        nf = fetch_log.size() - fetch_rd;
        np = psg_log.size() - psg_rd;
        check_eq({tag, " fetch count"}, 32'(nf), 32'(exp_fetch.size()));
        for (int i = 0; i < nf && i < exp_fetch.size(); i++)
            check_eq({tag, " fetch addr"}, 32'(fetch_log[fetch_rd + i]), 32'(exp_fetch[i]));
        check_eq({tag, " psg count"}, 32'(np), 32'(exp_psg.size()));
        for (int i = 0; i < np && i < exp_psg.size(); i++)
            check_eq({tag, " psg write"}, 32'(psg_log[psg_rd + i]), 32'(exp_psg[i]));
        check_eq({tag, " ch_active"}, 32'(ch_active), 32'(m_active));
        check_eq({tag, " dma_irq"}, 32'(dma_irq), 32'(m_irq));
        $display("pass %s: fetches %0d psg writes %0d active %b irq %b", tag, nf, np, ch_active, dma_irq);
        fetch_rd = fetch_log.size();
        psg_rd   = psg_log.size();
        exp_fetch.delete();
        exp_psg.delete();
    endtask

    task automatic run_pass(input string tag, output int nf, output int np);
        hsync_pulse();
        model_pass();
        repeat (60) @(negedge clk);
        check_logs(tag, nf, np);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, " mem_req"},   32'(mem_req),   0);
        check_eq({tag, " psg_req"},   32'(psg_req),   0);
        check_eq({tag, " mem_addr"},  32'(mem_addr),  0);
        check_eq({tag, " psg_reg"},   32'(psg_reg),   0);
        check_eq({tag, " psg_data"},  32'(psg_data),  0);
        check_eq({tag, " ch_active"}, 32'(ch_active), 0);
        check_eq({tag, " dma_irq"},   32'(dma_irq),   0);
        check_eq({tag, " overrun"},   32'(overrun),   0);
    endtask

    function automatic logic [15:0] last_fetch();
        if (fetch_log.size() == 0) return 16'hDEAD;
        return fetch_log[fetch_log.size() - 1];
    endfunction

    function automatic logic [15:0] rand_instr();
        int          r;
        logic [11:0] v;
        r = int'($urandom_range(9, 0));
        v = 12'($urandom);
        case (r)
            0, 1, 2, 3: return {4'h0, v};
            4:          return {4'h1, 12'($urandom_range(3, 0))};
            5:          return {4'h2, 12'($urandom_range(2, 0))};
            6, 7: begin
                v = 12'h001;
                if ($urandom_range(1, 0) == 1) v = v | 12'h010;
                if ($urandom_range(7, 0) == 0) v = v | 12'h020;
                return {4'h4, v};
            end
            default:    return {4'h3, v};
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int nf, np, tot;
        int exp_nf [8] = '{1, 0, 0, 0, 0, 0, 0, 1};
        bit seen_req;

        reset_n = 1'b0; hsync_i = 1'b0;
        cfg_we = 1'b0; cfg_sel = 2'd0; cfg_field = 2'd0; cfg_data = 8'd0;
        model_reset();
        repeat (4) @(negedge clk);
        check_reset("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single LOAD on channel 0, then pointer advance.
        mem_dly_max = 2;
        mem_m[16'h4000] = 16'h0712;
        set_chan(0, 16'h4000, 8'd0);
        run_pass("load1", nf, np);
        check_eq("load1 psg_reg", 32'(psg_reg), 32'h7);
        check_eq("load1 psg_data", 32'(psg_data), 32'h12);
        run_pass("load2", nf, np);
        check_eq("load2 next addr", 32'(last_fetch()), 32'h4002);
        cfg_write(0, 3, 8'h02);

        // PAUSE 3 with prescaler 1 skips six passes.
        mem_m[16'h1000] = 16'h1003;
        mem_m[16'h1002] = 16'h0801;
        set_chan(1, 16'h1000, 8'd1);
        for (int p = 0; p < 8; p++) begin
            run_pass("pause", nf, np);
            check_eq("pause fetches in pass", 32'(nf), 32'(exp_nf[p]));
        end
        cfg_write(1, 3, 8'h03);  // clear wins over enable

        // REPEAT 2 / LOAD / LOOP / STOP.
        mem_m[16'h2000] = 16'h2002;
        mem_m[16'h2002] = 16'h0900;
        mem_m[16'h2004] = 16'h4001;
        mem_m[16'h2006] = 16'h4020;
        set_chan(2, 16'h2000, 8'd0);
        tot = 0;
        for (int p = 0; p < 9; p++) begin
            run_pass("loop", nf, np);
            tot += np;
        end
        check_eq("loop load total", 32'(tot), 3);
        check_eq("loop ch2 stopped", 32'(ch_active[2]), 0);

        // INT with a same-cycle clear: set wins; a later clear removes it.
        mem_m[16'h3000] = 16'h4010;
        set_chan(0, 16'h3000, 8'd0);
        clr_at_int = 1'b1;
        run_pass("int", nf, np);
        clr_at_int = 1'b0;
        check_eq("int irq0 set", 32'(dma_irq[0]), 1);
        irq_clear(3'b001);
        check_eq("int irq0 cleared", 32'(dma_irq[0]), 0);

        // Long fetch spanning the next hsync edge.
        mem_m[16'h3100] = 16'h0155;
        set_chan(0, 16'h3100, 8'd0);
        mem_fix_dly = 200;
        hsync_pulse();
        model_pass();
        repeat (40) @(negedge clk);
        check_eq("overrun before", 32'(overrun), 0);
        check_eq("overrun mem_req held", 32'(mem_req), 1);
        hsync_pulse();
        repeat (260) @(negedge clk);
        mem_fix_dly = -1;
        check_eq("overrun set", 32'(overrun), 1);
        check_logs("overrun", nf, np);
        repeat (60) @(negedge clk);
        check_logs("no extra pass", nf, np);

        // Address wrap FFFE -> 0000, then reset during a PSG write.
        mem_m[16'hFFFE] = 16'h0A33;
        mem_m[16'h0000] = 16'h0B44;
        mem_m[16'h0002] = 16'h0C55;
        set_chan(0, 16'hFFFE, 8'd0);
        run_pass("wrap1", nf, np);
        run_pass("wrap2", nf, np);
        check_eq("wrap addr", 32'(last_fetch()), 32'h0000);
        psg_hold = 1'b1;
        hsync_pulse();
        seen_req = 1'b0;
        for (int i = 0; i < 50 && !seen_req; i++) begin
            @(negedge clk);
            seen_req = psg_req;
        end
        check_eq("psg_req before reset", 32'(seen_req), 1);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset("mid psg reset");
        reset_n = 1'b1;
        psg_hold = 1'b0;
        model_reset();
        late_ack_seq++;  // stray ack after reset must be ignored
        repeat (3) @(negedge clk);
        check_reset("late ack");
        run_pass("after reset", nf, np);

        // Randomized programs on all three channels.
        mem_dly_max = 3;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 64; k++)
                mem_m[16'h5000 + 16'(c * 16'h1000) + 16'(2 * k)] = rand_instr();
            set_chan(c, 16'h5000 + 16'(c * 16'h1000), 8'($urandom_range(2, 0)));
        end
        for (int p = 0; p < 40; p++) begin
            run_pass("random", nf, np);
            if ($urandom_range(3, 0) == 0) irq_clear(3'($urandom_range(7, 1)));
            for (int c = 0; c < 3; c++)
                if (!m_active[c] && $urandom_range(2, 0) == 0) cfg_write(c, 3, 8'h01);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
